// File: rtl/mem_rsp.sv
// Memory/IO responder: serves one access at a time from external SRAM (with wait states)
// or from keyboard/display device registers at 0xFE00-0xFE06. Optional macro: MEM_RSP_KBD_INT_EN.
module mem_rsp #(
    parameter int unsigned WAIT_CYC = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        kb_vld,
    input  logic [7:0]  kb_data,
    output logic        kb_rdy,
    output logic        dsp_vld,
    output logic [7:0]  dsp_data,
    input  logic        dsp_rdy,
    output logic        irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        r_w_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [15:0] rdata_q;
    logic        kbsr_full_q;
    logic [7:0]  kb_byte_q;
    logic        dsp_vld_q;
    logic [7:0]  dsp_data_q;
    logic        kbsr_ie;

    logic        accept;
    logic        acc_dev;
    logic        dev_q;
    logic        finish;
    logic        sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
    logic [15:0] dev_rdata;

    assign accept  = (state_q == ST_IDLE) && mio_en;
    assign acc_dev = (addr[15:9] == 7'h7F);
    assign dev_q   = (addr_q[15:9] == 7'h7F);
    assign finish  = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    assign sel_kbsr = (addr_q == ADDR_KBSR);
    assign sel_kbdr = (addr_q == ADDR_KBDR);
    assign sel_dsr  = (addr_q == ADDR_DSR);
    assign sel_ddr  = (addr_q == ADDR_DDR);

    // FSM next state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mio_en) begin
                    state_d = ST_BUSY;
                    cnt_d   = acc_dev ? 4'd0 : WAIT_LD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Access latch; the SRAM strobe fires only for non-device addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_q     <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            mem_req_q <= accept && !acc_dev;
            mem_we_q  <= accept && !acc_dev && r_w;
            if (accept) begin
                r_w_q   <= r_w;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        dev_rdata = 16'h0000;
        if (sel_kbsr) dev_rdata = {kbsr_full_q, kbsr_ie, 14'b0};
        if (sel_kbdr) dev_rdata = {8'h00, kb_byte_q};
        if (sel_dsr)  dev_rdata = {~dsp_vld_q, 15'b0};
        if (sel_ddr)  dev_rdata = {8'h00, dsp_data_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 16'h0000;
        end else if (finish && !r_w_q) begin
            rdata_q <= dev_q ? dev_rdata : mem_rdata;
        end
    end

    // Keyboard: kb_rdy is low while full, so capture and KBDR-read clear never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbsr_full_q <= 1'b0;
            kb_byte_q   <= 8'h00;
        end else if (kb_vld && !kbsr_full_q) begin
            kbsr_full_q <= 1'b1;
            kb_byte_q   <= kb_data;
        end else if ((state_q == ST_DONE) && !r_w_q && sel_kbdr) begin
            kbsr_full_q <= 1'b0;
        end
    end

    // Display: a DDR write while a byte is pending is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_vld_q  <= 1'b0;
            dsp_data_q <= 8'h00;
        end else if (dsp_vld_q && dsp_rdy) begin
            dsp_vld_q <= 1'b0;
        end else if (finish && r_w_q && sel_ddr && !dsp_vld_q) begin
            dsp_vld_q  <= 1'b1;
            dsp_data_q <= wdata_q[7:0];
        end
    end

`ifdef MEM_RSP_KBD_INT_EN
    logic kbsr_ie_q;
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbsr_ie_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= kbsr_full_q && kbsr_ie_q;
            if (finish && r_w_q && sel_kbsr) begin
                kbsr_ie_q <= wdata_q[14];
            end
        end
    end

    assign kbsr_ie = kbsr_ie_q;
    assign irq     = irq_q;
`else
    assign kbsr_ie = 1'b0;
    assign irq     = 1'b0;
`endif

    assign ready     = (state_q == ST_DONE);
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign kb_rdy    = ~kbsr_full_q;
    assign dsp_vld   = dsp_vld_q;
    assign dsp_data  = dsp_data_q;

endmodule

// File: tb/tb_mem_rsp.sv
// Directed self-checking bench for mem_rsp (WAIT_CYC = 3); honours MEM_RSP_KBD_INT_EN.
module tb_mem_rsp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mio_en, r_w;
    logic [15:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic        ready, mem_req, mem_we;
    logic        kb_vld, kb_rdy, dsp_vld, dsp_rdy, irq;
    logic [7:0]  kb_data, dsp_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Per-access observations
    int          lat, nreq;
    logic        req1, we1;
    logic [15:0] maddr1, mwd1;

    always #5 clk = ~clk;

    mem_rsp #(.WAIT_CYC(3)) dut (
        .clk(clk), .rst_n(rst_n), .mio_en(mio_en), .r_w(r_w), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .kb_vld(kb_vld), .kb_data(kb_data), .kb_rdy(kb_rdy), .dsp_vld(dsp_vld),
        .dsp_data(dsp_data), .dsp_rdy(dsp_rdy), .irq(irq)
    );

    // Returns #1 after the edge that raised ready; lat = cycle index T0+lat of ready, 0 on timeout
    task automatic do_access(input logic rw, input logic [15:0] a, input logic [15:0] wd);
        @(posedge clk);
        @(negedge clk);
        mio_en = 1'b1; r_w = rw; addr = a; wdata = wd;
        lat = 0; nreq = 0; req1 = 1'b0; we1 = 1'b0; maddr1 = 16'h0; mwd1 = 16'h0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (mem_req) nreq++;
            if (n == 1) begin
                req1 = mem_req; we1 = mem_we; maddr1 = mem_addr; mwd1 = mem_wdata;
            end
            if (ready) begin
                lat = n;
                break;
            end
        end
        mio_en = 1'b0;
    endtask

    task automatic kb_byte(input logic [7:0] d);
        @(negedge clk); kb_vld = 1'b1; kb_data = d;
        @(negedge clk); kb_vld = 1'b0;
    endtask

    task automatic test_reset;
        total_cnt++;
        if ({ready, mem_req, mem_we, dsp_vld, irq} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {ready, mem_req, mem_we, dsp_vld, irq});
        else pass_cnt++;
        total_cnt++;
        if ({rdata, mem_addr, mem_wdata, dsp_data} !== 56'h0)
            $display("FAIL reset_data: got %h want 0", {rdata, mem_addr, mem_wdata, dsp_data});
        else pass_cnt++;
        total_cnt++;
        if (kb_rdy !== 1'b1) $display("FAIL reset_kb_rdy: got %b want 1", kb_rdy);
        else pass_cnt++;
    endtask

    task automatic test_sram_read;
        mem_rdata = 16'hBEEF;
        do_access(1'b0, 16'h3000, 16'h0000);
        total_cnt++;
        if (lat !== 5) $display("FAIL sram_rd_lat: got %0d want 5", lat);
        else pass_cnt++;
        total_cnt++;
        if ({req1, we1, maddr1} !== {1'b1, 1'b0, 16'h3000})
            $display("FAIL sram_rd_strobe: got %b%b %h want 10 3000", req1, we1, maddr1);
        else pass_cnt++;
        total_cnt++;
        if (nreq !== 1) $display("FAIL sram_rd_req_cnt: got %0d want 1", nreq);
        else pass_cnt++;
        total_cnt++;
        if (rdata !== 16'hBEEF) $display("FAIL sram_rd_data: got %h want beef", rdata);
        else pass_cnt++;
    endtask

    task automatic test_sram_write;
        mem_rdata = 16'h5555;
        do_access(1'b1, 16'h4000, 16'h1234);
        total_cnt++;
        if ({req1, we1, maddr1, mwd1} !== {2'b11, 16'h4000, 16'h1234})
            $display("FAIL sram_wr_strobe: got %b%b %h %h want 11 4000 1234", req1, we1, maddr1, mwd1);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 5) $display("FAIL sram_wr_lat: got %0d want 5", lat);
        else pass_cnt++;
        total_cnt++;
        if (rdata !== 16'hBEEF) $display("FAIL sram_wr_rdata_kept: got %h want beef", rdata);
        else pass_cnt++;
    endtask

    task automatic test_keyboard;
        kb_byte(8'h41);
        total_cnt++;
        if (kb_rdy !== 1'b0) $display("FAIL kb_rdy_full: got %b want 0", kb_rdy);
        else pass_cnt++;
        do_access(1'b0, 16'hFE00, 16'h0000);
        total_cnt++;
        if ({lat, nreq} !== {32'd2, 32'd0})
            $display("FAIL kbsr_lat: got lat %0d req %0d want 2 0", lat, nreq);
        else pass_cnt++;
        total_cnt++;
        if (rdata !== 16'h8000) $display("FAIL kbsr_rd: got %h want 8000", rdata);
        else pass_cnt++;
        do_access(1'b0, 16'hFE02, 16'h0000);
        total_cnt++;
        if (rdata !== 16'h0041) $display("FAIL kbdr_rd: got %h want 0041", rdata);
        else pass_cnt++;
        total_cnt++;
        if (kb_rdy !== 1'b0) $display("FAIL kb_rdy_in_ready: got %b want 0", kb_rdy);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (kb_rdy !== 1'b1) $display("FAIL kb_rdy_after: got %b want 1", kb_rdy);
        else pass_cnt++;
    endtask

    task automatic test_display;
        dsp_rdy = 1'b0;
        do_access(1'b1, 16'hFE06, 16'h0058);
        total_cnt++;
        if ({dsp_vld, dsp_data} !== {1'b1, 8'h58})
            $display("FAIL ddr_wr1: got %b %h want 1 58", dsp_vld, dsp_data);
        else pass_cnt++;
        do_access(1'b0, 16'hFE04, 16'h0000);
        total_cnt++;
        if (rdata !== 16'h0000) $display("FAIL dsr_busy: got %h want 0000", rdata);
        else pass_cnt++;
        do_access(1'b1, 16'hFE06, 16'h0059);
        total_cnt++;
        if ({dsp_vld, dsp_data} !== {1'b1, 8'h58})
            $display("FAIL ddr_wr_drop: got %b %h want 1 58", dsp_vld, dsp_data);
        else pass_cnt++;
        @(negedge clk); dsp_rdy = 1'b1;
        @(negedge clk); dsp_rdy = 1'b0;
        total_cnt++;
        if (dsp_vld !== 1'b0) $display("FAIL dsp_consume: got %b want 0", dsp_vld);
        else pass_cnt++;
        do_access(1'b0, 16'hFE04, 16'h0000);
        total_cnt++;
        if (rdata !== 16'h8000) $display("FAIL dsr_idle: got %h want 8000", rdata);
        else pass_cnt++;
        do_access(1'b0, 16'hFE06, 16'h0000);
        total_cnt++;
        if (rdata !== 16'h0058) $display("FAIL ddr_rd: got %h want 0058", rdata);
        else pass_cnt++;
        do_access(1'b0, 16'hFE08, 16'h0000);
        total_cnt++;
        if ({rdata, lat, nreq} !== {16'h0000, 32'd2, 32'd0})
            $display("FAIL unmapped_rd: got %h lat %0d req %0d want 0000 2 0", rdata, lat, nreq);
        else pass_cnt++;
    endtask

    task automatic test_interrupt;
`ifdef MEM_RSP_KBD_INT_EN
        do_access(1'b1, 16'hFE00, 16'h4000);
        kb_byte(8'h5A);
        @(posedge clk); @(posedge clk); #1;
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_set: got %b want 1", irq);
        else pass_cnt++;
        do_access(1'b0, 16'hFE00, 16'h0000);
        total_cnt++;
        if (rdata !== 16'hC000) $display("FAIL kbsr_ie_rd: got %h want c000", rdata);
        else pass_cnt++;
`else
        do_access(1'b1, 16'hFE00, 16'hFFFF);
        kb_byte(8'h5A);
        @(posedge clk); @(posedge clk); #1;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_tied: got %b want 0", irq);
        else pass_cnt++;
        do_access(1'b0, 16'hFE00, 16'h0000);
        total_cnt++;
        if (rdata !== 16'h8000) $display("FAIL kbsr_ie_rd: got %h want 8000", rdata);
        else pass_cnt++;
`endif
        do_access(1'b0, 16'hFE02, 16'h0000);
        total_cnt++;
        if (rdata !== 16'h005A) $display("FAIL kbdr_rd2: got %h want 005a", rdata);
        else pass_cnt++;
        @(posedge clk); @(posedge clk); #1;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic saw_ready;
        kb_byte(8'h77);
        @(posedge clk);
        @(negedge clk);
        mio_en = 1'b1; r_w = 1'b0; addr = 16'hFE02;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        mio_en = 1'b0;
        total_cnt++;
        if ({ready, kb_rdy, rdata} !== {1'b0, 1'b1, 16'h0000})
            $display("FAIL rst_mid_state: got %b %b %h want 0 1 0000", ready, kb_rdy, rdata);
        else pass_cnt++;
        saw_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ready) saw_ready = 1'b1;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ready) saw_ready = 1'b1;
        end
        total_cnt++;
        if (saw_ready !== 1'b0) $display("FAIL rst_mid_no_ready: got %b want 0", saw_ready);
        else pass_cnt++;
        do_access(1'b0, 16'hFE04, 16'h0000);
        total_cnt++;
        if ({rdata, lat} !== {16'h8000, 32'd2})
            $display("FAIL rst_mid_idle: got %h lat %0d want 8000 2", rdata, lat);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; mio_en = 1'b0; r_w = 1'b0; addr = 16'h0; wdata = 16'h0;
        mem_rdata = 16'h0; kb_vld = 1'b0; kb_data = 8'h0; dsp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk); rst_n = 1'b1;
        test_sram_read;
        test_sram_write;
        test_keyboard;
        test_display;
        test_interrupt;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
